// File: rtl/sram_2rw_bytemask_init.sv
// ---------------------------------------------------------------------------
// sram_2rw_bytemask_init
//
// Generic two-port read/write SRAM model on a single clock. Each port can read
// or write one word per cycle, with per-byte-lane write masks and a pipelined
// read path of READ_LATENCY (1 or 2) cycles. After reset a clear sequencer
// writes zero to every implemented word. Port requests are accepted only
// once init_done is high.
//
// Write-write collision (same address, same cycle):
//   - lanes enabled in both masks take port 0 data;
//   - lanes enabled only by port 1 take port 1 data;
//   - wr_collision pulses on the next cycle.
//
// A read that collides with the other port's write returns the old word.
// Optional macro SRAM_WRITE_BYPASS_EN: such a read instead returns the merged
// post-write word.
//
// Ports:
//   clk, rst             single clock, synchronous active-high reset
//   csbN, webN           port N active-low chip select / write enable
//   wmaskN               port N byte-lane write enables (active high)
//   addrN, dinN          port N address / write data
//   doutN, doutN_valid   port N read data and one-cycle valid strobe
//   init_done            high once the clear sequence has finished
//   wr_collision         one-cycle pulse after a same-address write-write
// ---------------------------------------------------------------------------
module sram_2rw_bytemask_init #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 7,
  parameter int RAM_DEPTH    = 1 << ADDR_WIDTH,
  parameter int WORD_SIZE    = 8,
  parameter int NUM_WMASKS   = DATA_WIDTH / WORD_SIZE,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_valid,
  input  logic                  csb1,
  input  logic                  web1,
  input  logic [NUM_WMASKS-1:0] wmask1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] din1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  init_done,
  output logic                  wr_collision
);

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("sram_2rw_bytemask_init: READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % WORD_SIZE != 0) begin : g_bad_width
    $error("sram_2rw_bytemask_init: DATA_WIDTH must be a multiple of WORD_SIZE");
  end

  localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH + 1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  typedef enum logic [0:0] {ST_INIT, ST_READY} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   init_addr_q, init_addr_d;
  logic                    init_done_q;

  logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

  // Both ports gathered into 2-entry arrays so the datapath is written once.
  logic [ADDR_WIDTH-1:0]   addr_a  [2];
  logic [DATA_WIDTH-1:0]   din_a   [2];
  logic [NUM_WMASKS-1:0]   wmask_a [2];
  logic [1:0]              req, rd, wr, in_range;
  logic [DATA_WIDTH-1:0]   rd_word [2];
  logic                    collide;

  logic [1:0]              cap_valid;
  logic [DATA_WIDTH-1:0]   cap_data  [2];
  logic [1:0]              fin_valid;
  logic [DATA_WIDTH-1:0]   fin_data  [2];
  logic [1:0]              dout_valid_q;
  logic [DATA_WIDTH-1:0]   dout_q    [2];
  logic                    wr_collision_q;

  assign addr_a[0]  = addr0;
  assign addr_a[1]  = addr1;
  assign din_a[0]   = din0;
  assign din_a[1]   = din1;
  assign wmask_a[0] = wmask0;
  assign wmask_a[1] = wmask1;

  assign req      = {~csb1, ~csb0} & {2{init_done_q}};
  assign in_range = {({1'b0, addr1} < DEPTH_LIM), ({1'b0, addr0} < DEPTH_LIM)};
  assign rd       = req & {web1, web0};
  // Out-of-range writes are dropped here, so they can never collide either.
  assign wr       = req & ~{web1, web0} & in_range;
  assign collide  = wr[0] & wr[1] & (addr0 == addr1);

  // ---------------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (rst) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      // Registered from state, so init_done rises the cycle after READY.
      init_done_q <= (state_q == ST_READY);
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first; a missed branch
    // would otherwise infer a latch.
    state_d     = state_q;
    init_addr_d = init_addr_q;
    case (state_q)
      ST_INIT: begin
        init_addr_d = init_addr_q + 1'b1;
        if (init_addr_q == LAST_ADDR) begin
          state_d     = ST_READY;
          init_addr_d = '0;
        end
      end
      ST_READY: ;
      default: state_d = ST_INIT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset branch; it maps onto plain RAM, and the clear
  // sequencer provides defined contents before any request is accepted.
  always_ff @(posedge clk) begin
    if (!rst && state_q == ST_INIT) begin
      mem[init_addr_q] <= '0;
    end else begin
      // Port 1 is applied first so port 0's later assignment wins shared lanes.
      for (int p = 1; p >= 0; p--) begin
        if (wr[p]) begin
          for (int i = 0; i < NUM_WMASKS; i++) begin
            if (wmask_a[p][i]) begin
              mem[addr_a[p]][i*WORD_SIZE +: WORD_SIZE] <= din_a[p][i*WORD_SIZE +: WORD_SIZE];
            end
          end
        end
      end
    end
  end

`ifdef SRAM_WRITE_BYPASS_EN
  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] base,
    input logic [DATA_WIDTH-1:0] data,
    input logic [NUM_WMASKS-1:0] mask
  );
    logic [DATA_WIDTH-1:0] w;
    w = base;
    for (int i = 0; i < NUM_WMASKS; i++) begin
      if (mask[i]) w[i*WORD_SIZE +: WORD_SIZE] = data[i*WORD_SIZE +: WORD_SIZE];
    end
    return w;
  endfunction
`endif

  // Word captured by a read at this edge; out-of-range reads return zero.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_word[p] = '0;
      if (in_range[p]) rd_word[p] = mem[addr_a[p]];
`ifdef SRAM_WRITE_BYPASS_EN
      // A reading port cannot also write, so only the other port can update
      // the word being read.
      if (rd[p] && wr[1-p] && addr_a[1-p] == addr_a[p]) begin
        rd_word[p] = merge_lanes(rd_word[p], din_a[1-p], wmask_a[1-p]);
      end
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipelines: capture at the sampling edge, optional middle stage, then
  // the output register that updates READ_LATENCY edges after sampling.
  // ---------------------------------------------------------------------------
  if (READ_LATENCY == 2) begin : g_lat2
    logic [1:0]            s2_valid;
    logic [DATA_WIDTH-1:0] s2_data [2];

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid <= '0;
        s2_data  <= '{default: '0};
      end else begin
        s2_valid <= cap_valid;
        for (int p = 0; p < 2; p++) begin
          if (cap_valid[p]) s2_data[p] <= cap_data[p];
        end
      end
    end

    assign fin_valid = s2_valid;
    assign fin_data  = s2_data;
  end else begin : g_lat1
    assign fin_valid = cap_valid;
    assign fin_data  = cap_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_valid      <= '0;
      cap_data       <= '{default: '0};
      dout_valid_q   <= '0;
      dout_q         <= '{default: '0};
      wr_collision_q <= 1'b0;
    end else begin
      cap_valid    <= rd;
      dout_valid_q <= fin_valid;
      for (int p = 0; p < 2; p++) begin
        if (rd[p])        cap_data[p] <= rd_word[p];
        if (fin_valid[p]) dout_q[p]   <= fin_data[p];
      end
      wr_collision_q <= collide;
    end
  end

  assign dout0        = dout_q[0];
  assign dout1        = dout_q[1];
  assign dout0_valid  = dout_valid_q[0];
  assign dout1_valid  = dout_valid_q[1];
  assign init_done    = init_done_q;
  assign wr_collision = wr_collision_q;

endmodule

// File: tb/tb_sram_2rw_bytemask_init.sv
// ---------------------------------------------------------------------------
// tb_sram_2rw_bytemask_init
//
// Directed bench driving two instances from the same stimulus:
//   dut_a - 128 words, READ_LATENCY 1
//   dut_b - 100 words, READ_LATENCY 2
// Inputs change on the falling edge; outputs are checked on the falling edge
// after the rising edge of interest.
// ---------------------------------------------------------------------------
module tb_sram_2rw_bytemask_init;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csb0 = 1'b1, web0 = 1'b1, csb1 = 1'b1, web1 = 1'b1;
  logic [3:0]  wmask0 = '0, wmask1 = '0;
  logic [6:0]  addr0 = '0, addr1 = '0;
  logic [31:0] din0 = '0, din1 = '0;

  logic [31:0] a_dout0, a_dout1, b_dout0, b_dout1;
  logic        a_dout0_valid, a_dout1_valid, a_init_done, a_wr_collision;
  logic        b_dout0_valid, b_dout1_valid, b_init_done, b_wr_collision;

  int checks = 0;
  int errors = 0;

  logic [6:0]  pipe_addr [4] = '{7'd1, 7'd2, 7'd120, 7'd20};
  logic [31:0] pipe_exp_a [4] = '{32'h0A0B0C0D, 32'h12345678, 32'hFFFFFFFF, 32'h0};
  logic [31:0] pipe_exp_b [4] = '{32'h0A0B0C0D, 32'h12345678, 32'h0, 32'h0};
  logic [31:0] rw_exp;

  int  ca, cb;
  bit  early_valid;

  always #5 clk = ~clk;

  sram_2rw_bytemask_init #(
    .DATA_WIDTH(32), .ADDR_WIDTH(7), .RAM_DEPTH(128), .WORD_SIZE(8), .READ_LATENCY(1)
  ) dut_a (
    .clk(clk), .rst(rst),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(a_dout0), .dout0_valid(a_dout0_valid),
    .csb1(csb1), .web1(web1), .wmask1(wmask1), .addr1(addr1), .din1(din1),
    .dout1(a_dout1), .dout1_valid(a_dout1_valid),
    .init_done(a_init_done), .wr_collision(a_wr_collision)
  );

  sram_2rw_bytemask_init #(
    .DATA_WIDTH(32), .ADDR_WIDTH(7), .RAM_DEPTH(100), .WORD_SIZE(8), .READ_LATENCY(2)
  ) dut_b (
    .clk(clk), .rst(rst),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(b_dout0), .dout0_valid(b_dout0_valid),
    .csb1(csb1), .web1(web1), .wmask1(wmask1), .addr1(addr1), .din1(din1),
    .dout1(b_dout1), .dout1_valid(b_dout1_valid),
    .init_done(b_init_done), .wr_collision(b_wr_collision)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    csb0 = 1'b1; web0 = 1'b1; wmask0 = '0;
    csb1 = 1'b1; web1 = 1'b1; wmask1 = '0;
  endtask

  task automatic wr0(input logic [6:0] a, input logic [31:0] d, input logic [3:0] m);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
  endtask

  task automatic wr1(input logic [6:0] a, input logic [31:0] d, input logic [3:0] m);
    csb1 = 1'b0; web1 = 1'b0; addr1 = a; din1 = d; wmask1 = m;
  endtask

  task automatic rd0(input logic [6:0] a);
    csb0 = 1'b0; web0 = 1'b1; addr0 = a; wmask0 = '0;
  endtask

  task automatic rd1(input logic [6:0] a);
    csb1 = 1'b0; web1 = 1'b1; addr1 = a; wmask1 = '0;
  endtask

  // Called on the falling edge where rst was just released. Holds a port 0
  // read of 0x7F throughout and counts edges until each init_done is seen.
  task automatic measure_init(output int cnt_a, output int cnt_b, output bit early);
    cnt_a = -1; cnt_b = -1; early = 1'b0;
    rd0(7'h7F);
    for (int n = 1; n <= 400 && (cnt_a < 0 || cnt_b < 0); n++) begin
      step();
      if (!a_init_done && a_dout0_valid) early = 1'b1;
      if (!b_init_done && b_dout0_valid) early = 1'b1;
      if (a_init_done && cnt_a < 0) cnt_a = n;
      if (b_init_done && cnt_b < 0) cnt_b = n;
    end
    idle();
  endtask

  initial begin
    // ---------------- Reset state ----------------
    idle();
    rst = 1'b1;
    step(); step();
    check("rst_a_dout0", a_dout0, 32'h0);
    check("rst_a_dout0_valid", a_dout0_valid, 1'b0);
    check("rst_a_init_done", a_init_done, 1'b0);
    check("rst_a_wr_collision", a_wr_collision, 1'b0);
    check("rst_b_dout1", b_dout1, 32'h0);
    check("rst_b_dout1_valid", b_dout1_valid, 1'b0);
    check("rst_b_init_done", b_init_done, 1'b0);

    // ---------------- Init timing ----------------
    rst = 1'b0;
    measure_init(ca, cb, early_valid);
    check("init_a_cycles", ca, 32'd129);
    check("init_b_cycles", cb, 32'd101);
    check("init_no_early_valid", early_valid, 1'b0);
    repeat (3) step();

    // Read of 0x7F after init: cleared word on A, out-of-range zero on B.
    rd0(7'h7F);
    step(); idle();
    step();
    check("rd7f_a_valid", a_dout0_valid, 1'b1);
    check("rd7f_a_data", a_dout0, 32'h0);
    check("rd7f_b_valid_early", b_dout0_valid, 1'b0);
    step();
    check("rd7f_b_valid", b_dout0_valid, 1'b1);
    check("rd7f_b_data", b_dout0, 32'h0);

    // ---------------- Mid-init reset ----------------
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (50) step();
    check("mid_a_not_done", a_init_done, 1'b0);
    check("mid_b_not_done", b_init_done, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    measure_init(ca, cb, early_valid);
    check("reinit_a_cycles", ca, 32'd129);
    check("reinit_b_cycles", cb, 32'd101);
    check("reinit_no_early_valid", early_valid, 1'b0);
    repeat (3) step();

    // ---------------- Byte mask ----------------
    wr0(7'd5, 32'hAABBCCDD, 4'hF);
    step();
    wr0(7'd5, 32'h11223344, 4'h5);
    step();
    idle(); rd1(7'd5);
    step();
    idle();
    step();
    check("mask_a_valid", a_dout1_valid, 1'b1);
    check("mask_a_data", a_dout1, 32'hAA22CC44);
    check("mask_b_valid_early", b_dout1_valid, 1'b0);
    step();
    check("mask_a_valid_pulse", a_dout1_valid, 1'b0);
    check("mask_b_valid", b_dout1_valid, 1'b1);
    check("mask_b_data", b_dout1, 32'hAA22CC44);
    step();
    check("mask_b_valid_pulse", b_dout1_valid, 1'b0);
    check("mask_b_hold", b_dout1, 32'hAA22CC44);

    // ---------------- Write-write collision ----------------
    wr0(7'd9, 32'h11111111, 4'h3);
    wr1(7'd9, 32'h22222222, 4'h6);
    step();
    idle();
    check("coll_a_pulse", a_wr_collision, 1'b1);
    check("coll_b_pulse", b_wr_collision, 1'b1);
    step();
    check("coll_a_once", a_wr_collision, 1'b0);
    check("coll_b_once", b_wr_collision, 1'b0);
    rd0(7'd9);
    step(); idle();
    step();
    check("coll_a_data", a_dout0, 32'h00221111);
    step();
    check("coll_b_data", b_dout0, 32'h00221111);

    // ---------------- Read-write collision ----------------
`ifdef SRAM_WRITE_BYPASS_EN
    rw_exp = 32'h01020304;
`else
    rw_exp = 32'hDEADBEEF;
`endif
    wr0(7'd3, 32'hDEADBEEF, 4'hF);
    step();
    wr0(7'd3, 32'h01020304, 4'hF);
    rd1(7'd3);
    step(); idle();
    step();
    check("rw_a_valid", a_dout1_valid, 1'b1);
    check("rw_a_data", a_dout1, rw_exp);
    step();
    check("rw_b_valid", b_dout1_valid, 1'b1);
    check("rw_b_data", b_dout1, rw_exp);
    rd1(7'd3);
    step(); idle();
    step();
    check("rw_a_after", a_dout1, 32'h01020304);
    step();
    check("rw_b_after", b_dout1, 32'h01020304);

    // ---------------- Pipelining and out-of-range ----------------
    wr0(7'd1, 32'h0A0B0C0D, 4'hF);
    wr1(7'd2, 32'h12345678, 4'hF);
    step();
    idle();
    check("diff_addr_no_coll", b_wr_collision, 1'b0);
    wr0(7'd120, 32'hFFFFFFFF, 4'hF);
    step();
    idle();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) rd0(pipe_addr[i]);
      else       idle();
      step();
      if (i >= 1 && i <= 4) begin
        check($sformatf("pipe_a_valid_%0d", i), a_dout0_valid, 1'b1);
        check($sformatf("pipe_a_data_%0d", i), a_dout0, pipe_exp_a[i-1]);
      end else begin
        check($sformatf("pipe_a_idle_%0d", i), a_dout0_valid, 1'b0);
      end
      if (i >= 2) begin
        check($sformatf("pipe_b_valid_%0d", i), b_dout0_valid, 1'b1);
        check($sformatf("pipe_b_data_%0d", i), b_dout0, pipe_exp_b[i-2]);
      end else begin
        check($sformatf("pipe_b_idle_%0d", i), b_dout0_valid, 1'b0);
      end
    end
    step();
    check("pipe_b_drained", b_dout0_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_2rw_bytemask_init.md
Name: sram_2rw_bytemask_init

Overview:
- Parametrised successor to the team's 32x128 two-port RW SRAM model.
- Two synchronous RW ports on a single clock, adding:
  - configurable width and depth
  - per-byte write masks
  - configurable read latency
  - defined write-write collision resolution
  - a hardware clear sequencer after reset
- Sits beside the cache/register-file backends as the generic on-chip storage macro model; synthesizable, with no # delays and no X on outputs.

Parameters:
DATA_WIDTH, 32, bits per word; must be a multiple of WORD_SIZE
ADDR_WIDTH, 7, address bits per port
RAM_DEPTH, 1<<ADDR_WIDTH, number of implemented words; may be less than 2^ADDR_WIDTH
WORD_SIZE, 8, bits per write-mask lane
NUM_WMASKS, DATA_WIDTH/WORD_SIZE, mask lanes per port (derived)
READ_LATENCY, 1, cycles from sampled read request to dout; legal values 1 or 2, any other value fails at elaboration

Ports:
clk  input  1  single clock for both ports
rst  input  1  synchronous active-high reset
csb0  input  1  port 0 active-low chip select
web0  input  1  port 0 active-low write enable
wmask0  input  NUM_WMASKS  port 0 byte-lane write enables (active high)
addr0  input  ADDR_WIDTH  port 0 address
din0  input  DATA_WIDTH  port 0 write data
dout0  output  DATA_WIDTH  port 0 read data
dout0_valid  output  1  high for one cycle when dout0 carries new read data
csb1, web1, wmask1, addr1, din1, dout1, dout1_valid: same as port 0, for port 1
init_done  output  1  high once the clear sequence completes; requests accepted only while high
wr_collision  output  1  one-cycle pulse: both ports wrote the same address in the same cycle

Behaviour:
- Reset: rst sampled high at posedge sets:
  - dout0 = dout1 = 0, dout*_valid = 0, init_done = 0, wr_collision = 0
  - FSM to INIT with init_addr = 0
- Memory contents are not touched by reset itself; the INIT sequence clears them.
- FSM INIT:
  - Each cycle writes 0 to mem[init_addr], then init_addr increments.
  - After writing RAM_DEPTH-1 the FSM moves to READY; init_done rises on the following cycle. The clear takes exactly RAM_DEPTH cycles after reset deassert.
  - Port requests during INIT are ignored: no write, dout*_valid stays 0.
- rst asserted at any point, including mid-INIT, restarts INIT from address 0.
- FSM READY has no exit other than rst.
- Request sampling: a request is active at a posedge when csbN=0 and init_done=1.
- Write (webN=0):
  - Lane i of mem[addrN] takes din lane i iff wmaskN[i]=1; other lanes are retained.
  - The new value is visible to reads sampled on the next posedge.
  - A write with all mask bits 0 is a legal no-op.
- Read (webN=1):
  - mem[addrN] is captured at the sampling posedge.
  - doutN updates, and doutN_valid pulses, READ_LATENCY cycles after that edge.
  - doutN holds its last value when no read completes.
  - Back-to-back reads give one result per cycle (fully pipelined).
- Out-of-range address (addr >= RAM_DEPTH): writes are dropped; reads return 0 with valid asserted.
- Write-write collision, same address, same cycle:
  - Port 0 wins on lanes enabled in both masks.
  - Lanes enabled only in wmask1 take din1.
  - wr_collision pulses the following cycle.
  - Collisions on out-of-range addresses do not pulse.
- Read-write collision, port A reads the address port B writes in the same cycle: port A returns the pre-write data (default).
- Each port's read pipeline is independent; a read's pipeline stages are flushed by rst (valid cleared).

Optional Feature:
- Macro: SRAM_WRITE_BYPASS_EN.
- Defined: a read-write collision returns the post-write merged word, i.e. old word with port B's enabled lanes replaced by din B, including port-0-wins merging if both ports also write.
- Undefined: old data is returned as stated above.
- All other behaviour is identical either way.

Test Plan:
- Init: assert rst 2 cycles, then release → init_done rises exactly RAM_DEPTH+1 cycles after release. A read of addr 0x7F issued before init_done gives no dout0_valid; the same read after init_done returns 0x00000000.
- Mid-init reset: rst at init cycle 50 → count restarts and init_done rises RAM_DEPTH+1 cycles after the second release.
- Byte mask on port 0, READ_LATENCY=2: write 0xAABBCCDD to addr 5 with mask 0xF, then write 0x11223344 with mask 0x5 → port 1 read of addr 5 returns 0xAA22CC44 two cycles after sampling, with dout1_valid high for 1 cycle.
- Write collision at addr 9 (pre-value 0x0): port 0 writes 0x11111111 with mask 0x3, port 1 writes 0x22222222 with mask 0x6 → mem[9] = 0x00221111 and wr_collision pulses once.
- Read-write collision: mem[3]=0xDEADBEEF; port 0 writes 0x01020304 with mask 0xF while port 1 reads 3 → dout1 = 0xDEADBEEF without the macro, 0x01020304 with SRAM_WRITE_BYPASS_EN.
- Pipelining and out-of-range: RAM_DEPTH=100; back-to-back reads of addrs 1, 2, 120 → three consecutive valid cycles returning mem[1], mem[2], 0. A write to addr 120 leaves all memory unchanged.
